// File: rtl/reset_pulse_sequencer.sv
// Per-channel reset pulse sequencer: assert a channel mask, hold it, then release channels lowest-first.
// Latency: rst_out rises one cycle after accept, first release hold cycles later, done one cycle after last release.
// Backpressure: req_ready is low while a sequence runs; the requester holds req_valid. Optional macro RST_SEQ_ABORT_EN adds abort/aborted.
module reset_pulse_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int POR_GAP = 2
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NUM_CH-1:0] req_mask,
  input  logic [CNT_W-1:0]  hold_cycles,
  input  logic [CNT_W-1:0]  gap_cycles,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done,
`ifdef RST_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [NUM_CH-1:0] last_mask
);

  typedef enum logic [2:0] {
    S_POR, S_IDLE, S_ASSERT, S_HOLD, S_RELEASE, S_GAP, S_DONE
  } state_t;

  localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  POR_LOAD = CNT_W'(POR_GAP);

  state_t              state;
  logic [NUM_CH-1:0]   rem;      // channels still waiting to be released
  logic [NUM_CH-1:0]   mask_q;
  logic [CNT_W-1:0]    hold_q;
  logic [CNT_W-1:0]    gap_q;
  logic [CNT_W-1:0]    cnt;

  logic [NUM_CH-1:0]   low_bit;
  logic [NUM_CH-1:0]   rem_next;
  logic [CNT_W-1:0]    hold_m1;
  logic                abort_hit;

  // Lowest pending channel; unmasked channels are skipped for free by the priority encode.
  always_comb begin
    low_bit  = rem & ~(rem - CH_ONE);
    rem_next = rem & ~low_bit;
    hold_m1  = (hold_q == '0) ? '0 : (hold_q - CNT_ONE);
  end

`ifdef RST_SEQ_ABORT_EN
  // Abort only matters once a request sequence is actually running.
  always_comb begin
    abort_hit = abort && ((state == S_ASSERT) || (state == S_HOLD) ||
                          (state == S_RELEASE) || (state == S_GAP));
  end
`else
  assign abort_hit = 1'b0;
`endif

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_POR;
      rem       <= '1;
      mask_q    <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
      cnt       <= '0;
      rst_out   <= '1;
      busy      <= 1'b1;
      req_ready <= 1'b0;
      done      <= 1'b0;
      last_mask <= '0;
`ifdef RST_SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else if (abort_hit) begin
      // Drop every channel still held by this request and finish in one step.
      rst_out   <= rst_out & ~rem;
      rem       <= '0;
      done      <= 1'b1;
      busy      <= 1'b0;
      req_ready <= 1'b1;
      last_mask <= mask_q;
      state     <= S_IDLE;
`ifdef RST_SEQ_ABORT_EN
      aborted   <= 1'b1;
`endif
    end else begin
      case (state)
        S_POR: begin
          if (cnt == '0) begin
            rst_out <= rst_out & ~low_bit;
            rem     <= rem_next;
            cnt     <= POR_LOAD;
            if (rem_next == '0) begin
              busy      <= 1'b0;
              req_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_IDLE: begin
          done <= 1'b0;
`ifdef RST_SEQ_ABORT_EN
          aborted <= 1'b0;
`endif
          if (req_valid && req_ready) begin
            mask_q    <= req_mask;
            hold_q    <= hold_cycles;
            gap_q     <= gap_cycles;
            rem       <= req_mask;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= (req_mask == '0) ? S_DONE : S_ASSERT;
          end
        end
        S_ASSERT: begin
          rst_out <= rst_out | mask_q;
          cnt     <= hold_m1;
          state   <= (hold_m1 == '0) ? S_RELEASE : S_HOLD;
        end
        S_HOLD: begin
          cnt <= cnt - CNT_ONE;
          if (cnt <= CNT_ONE) state <= S_RELEASE;
        end
        S_RELEASE: begin
          rst_out <= rst_out & ~low_bit;
          rem     <= rem_next;
          if (rem_next == '0) begin
            state <= S_DONE;
          end else if (gap_q != '0) begin
            cnt   <= gap_q;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          cnt <= cnt - CNT_ONE;
          if (cnt <= CNT_ONE) state <= S_RELEASE;
        end
        S_DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          last_mask <= mask_q;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_pulse_sequencer.sv
// Bench for reset_pulse_sequencer: timeline model checked every cycle plus literal spot checks.
// Latency: outputs sampled on the falling edge, after the registered update.
// Backpressure: held requests are modelled as accepted on the first edge with req_ready high.
module tb_reset_pulse_sequencer;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int POR_GAP = 2;
  localparam int POR_END = (NUM_CH - 1) * (POR_GAP + 1) + 1;

  logic              tb_ACLK = 1'b0;
  logic              ARESET  = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [NUM_CH-1:0] req_mask = '0;
  logic [CNT_W-1:0]  hold_cycles = '0;
  logic [CNT_W-1:0]  gap_cycles = '0;
  logic [NUM_CH-1:0] rst_out;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] last_mask;
`ifdef RST_SEQ_ABORT_EN
  logic              abort = 1'b0;
  logic              aborted;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  reset_pulse_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .POR_GAP(POR_GAP)) dut (
    .ACLK        (tb_ACLK),
    .ARESET      (ARESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mask    (req_mask),
    .hold_cycles (hold_cycles),
    .gap_cycles  (gap_cycles),
    .rst_out     (rst_out),
    .busy        (busy),
    .done        (done),
`ifdef RST_SEQ_ABORT_EN
    .abort       (abort),
    .aborted     (aborted),
`endif
    .last_mask   (last_mask)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  // Timeline model: ecount = rising edges since reset released; one request tracked at a time.
  int                ecount      = 0;
  int                m_acc       = -1;
  logic [NUM_CH-1:0] m_mask      = '0;
  int                m_rel [NUM_CH];
  int                m_done_at   = -1;
  int                m_ab_at     = -1;
  logic [NUM_CH-1:0] m_prev_last = '0;

  function automatic logic exp_busy(input int e);
    if (e < POR_END) return 1'b1;
    return (m_acc >= 0) && (e >= m_acc) && (e < m_done_at);
  endfunction

  function automatic logic [NUM_CH-1:0] exp_rst(input int e);
    logic [NUM_CH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (e < POR_END) r[i] = (e < i * (POR_GAP + 1) + 1);
      else if (m_acc >= 0 && m_mask[i] && e >= m_acc + 1 && e < m_rel[i]) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic exp_done(input int e);
    return (m_acc >= 0) && (e == m_done_at);
  endfunction

  function automatic logic [NUM_CH-1:0] exp_last(input int e);
    if (m_acc >= 0 && e >= m_done_at) return m_mask;
    return m_prev_last;
  endfunction

  always @(posedge tb_ACLK or posedge ARESET) begin
    if (ARESET) begin
      ecount      = 0;
      m_acc       = -1;
      m_done_at   = -1;
      m_ab_at     = -1;
      m_prev_last = '0;
    end else begin
      int eo;
      eo     = ecount;
      ecount = eo + 1;
`ifdef RST_SEQ_ABORT_EN
      if (abort && m_acc >= 0 && ecount >= m_acc + 1 && ecount <= m_done_at - 1) begin
        for (int i = 0; i < NUM_CH; i++) if (m_rel[i] > ecount) m_rel[i] = ecount;
        m_done_at = ecount;
        m_ab_at   = ecount;
      end
`endif
      if (req_valid && !exp_busy(eo)) begin
        int t;
        int hp;
        bit first;
        m_prev_last = exp_last(eo);
        m_acc   = ecount;
        m_mask  = req_mask;
        m_ab_at = -1;
        hp      = (hold_cycles == 0) ? 1 : int'(hold_cycles);
        t       = m_acc + 1 + hp;
        first   = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          m_rel[i] = 0;
          if (req_mask[i]) begin
            if (!first) t = t + int'(gap_cycles) + 1;
            m_rel[i] = t;
            first = 1'b0;
          end
        end
        m_done_at = (req_mask == '0) ? m_acc + 1 : t + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, act, exp, ecount, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge tb_ACLK) begin
    chk("rst_out",   32'(rst_out),   32'(exp_rst(ecount)));
    chk("busy",      32'(busy),      32'(exp_busy(ecount)));
    chk("req_ready", 32'(req_ready), 32'(!exp_busy(ecount)));
    chk("done",      32'(done),      32'(exp_done(ecount)));
    chk("last_mask", 32'(last_mask), 32'(exp_last(ecount)));
`ifdef RST_SEQ_ABORT_EN
    chk("aborted",   32'(aborted),   32'(m_ab_at >= 0 && ecount == m_ab_at));
`endif
  end

  task automatic wait_e(input int n);
    int guard;
    guard = 0;
    while (ecount < n && guard < 200) begin
      @(negedge tb_ACLK);
      guard++;
    end
    if (ecount != n) chk("wait_edge", 32'(ecount), 32'(n));
  endtask

  task automatic drive(input logic v, input logic [NUM_CH-1:0] m,
                       input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] g);
    req_valid   = v;
    req_mask    = m;
    hold_cycles = h;
    gap_cycles  = g;
  endtask

  int s5;

  initial begin
    #1 ARESET = 1'b1;
    repeat (5) @(negedge tb_ACLK);
    chk("por_rst_in_reset", 32'(rst_out), 32'h0000000F);
    chk("por_busy_in_reset", 32'(busy), 32'd1);
    chk("por_ready_in_reset", 32'(req_ready), 32'd0);
    chk("por_last_in_reset", 32'(last_mask), 32'd0);
    ARESET = 1'b0;

    // Power-on release: one channel every three edges.
    wait_e(1);  chk("por_e1", 32'(rst_out), 32'b1110);
    wait_e(4);  chk("por_e4", 32'(rst_out), 32'b1100);
    wait_e(7);  chk("por_e7", 32'(rst_out), 32'b1000);
    wait_e(9);  chk("por_busy_e9", 32'(busy), 32'd1);
    wait_e(10); chk("por_rst_end", 32'(rst_out), 32'd0);
    chk("por_ready_end", 32'(req_ready), 32'd1);

    // mask 0101, hold 3, gap 0, accepted at edge 11; inputs then scrambled while busy.
    drive(1'b1, 4'b0101, 16'd3, 16'd0);
    wait_e(11); drive(1'b0, 4'b1111, 16'd7, 16'd5);
    wait_e(12); chk("r2_assert", 32'(rst_out), 32'b0101);
    wait_e(13); drive(1'b1, 4'b1000, 16'd0, 16'd0);
    chk("r2_ready_busy", 32'(req_ready), 32'd0);
    wait_e(15); chk("r2_bit0_rel", 32'(rst_out), 32'b0100);
    wait_e(16); chk("r2_bit2_rel", 32'(rst_out), 32'b0000);
    chk("r2_no_early_done", 32'(done), 32'd0);
    wait_e(17); chk("r2_done", 32'(done), 32'd1);
    chk("r2_last", 32'(last_mask), 32'b0101);

    // Held request (mask 1000, hold 0) taken in the done cycle, accepted at edge 18.
    wait_e(18); req_valid = 1'b0;
    chk("r2_done_pulse_end", 32'(done), 32'd0);
    wait_e(19); chk("r3_assert", 32'(rst_out), 32'b1000);
    wait_e(20); chk("r3_release", 32'(rst_out), 32'b0000);
    wait_e(21); chk("r3_done", 32'(done), 32'd1);
    chk("r3_last", 32'(last_mask), 32'b1000);

    // Empty mask accepted in the done cycle: done the following cycle, outputs untouched.
    drive(1'b1, 4'b0000, 16'd5, 16'd5);
    wait_e(22); req_valid = 1'b0;
    chk("r4_busy", 32'(busy), 32'd1);
    wait_e(23); chk("r4_done", 32'(done), 32'd1);
    chk("r4_last", 32'(last_mask), 32'd0);
    chk("r4_rst", 32'(rst_out), 32'd0);

    // mask 1011, hold 2, gap 2, accepted at edge 25.
    wait_e(24); drive(1'b1, 4'b1011, 16'd2, 16'd2);
    wait_e(25); req_valid = 1'b0;
    wait_e(26); chk("gap_assert", 32'(rst_out), 32'b1011);
    wait_e(28); chk("gap_rel0", 32'(rst_out), 32'b1010);
    wait_e(30); chk("gap_hold1", 32'(rst_out), 32'b1010);
    wait_e(31); chk("gap_rel1", 32'(rst_out), 32'b1000);
    wait_e(34); chk("gap_rel3", 32'(rst_out), 32'b0000);
    wait_e(35); chk("gap_done", 32'(done), 32'd1);
    chk("gap_last", 32'(last_mask), 32'b1011);

`ifdef RST_SEQ_ABORT_EN
    // mask 1111, hold 10, accepted at edge 37, abort raised after edge 41.
    wait_e(36); drive(1'b1, 4'b1111, 16'd10, 16'd0);
    wait_e(37); req_valid = 1'b0;
    wait_e(41); abort = 1'b1;
    chk("ab_held", 32'(rst_out), 32'b1111);
    wait_e(42); abort = 1'b0;
    chk("ab_rst", 32'(rst_out), 32'd0);
    chk("ab_done", 32'(done), 32'd1);
    chk("ab_aborted", 32'(aborted), 32'd1);
    wait_e(43); chk("ab_done_end", 32'(done), 32'd0);
    chk("ab_aborted_end", 32'(aborted), 32'd0);
    chk("ab_last", 32'(last_mask), 32'b1111);
`endif

    // ARESET during the hold of mask 0010.
    s5 = 44;
    wait_e(s5); drive(1'b1, 4'b0010, 16'd20, 16'd0);
    wait_e(s5 + 1); req_valid = 1'b0;
    wait_e(s5 + 2); chk("r5_assert", 32'(rst_out), 32'b0010);
    wait_e(s5 + 5);
    #2 ARESET = 1'b1;
    #1 chk("r5_async_rst", 32'(rst_out), 32'h0000000F);
    chk("r5_async_busy", 32'(busy), 32'd1);
    chk("r5_async_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge tb_ACLK);
    ARESET = 1'b0;
    wait_e(1);  chk("r5_por_e1", 32'(rst_out), 32'b1110);
    wait_e(4);  chk("r5_por_e4", 32'(rst_out), 32'b1100);
    wait_e(10); chk("r5_por_end", 32'(rst_out), 32'd0);
    chk("r5_por_ready", 32'(req_ready), 32'd1);
    chk("r5_last_cleared", 32'(last_mask), 32'd0);
    repeat (3) @(negedge tb_ACLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
